// File: rtl/dff_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dff_pkg                                                         |
// | Brief    : Mode encodings shared by the dff_pipe register pipeline.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package dff_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_SHIFT  = 2'b01,
    MODE_LOAD   = 2'b10,
    MODE_ROTATE = 2'b11
  } mode_e;

endpackage
`default_nettype wire

// File: rtl/dff_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dff_stage                                                       |
// | Brief    : One pipeline stage: WIDTH-bit register plus valid bit.          |
// |            sel=1 takes the parallel-load value, sel=0 the shift source.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dff_stage #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             sel,
  input  logic [WIDTH-1:0] shift_data,
  input  logic             shift_vld,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data,
  output logic             vld
);

  logic [WIDTH-1:0] r_data;
  logic             r_vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= RST_VAL;
      r_vld  <= 1'b0;
    end else if (clr) begin
      r_data <= RST_VAL;
      r_vld  <= 1'b0;
    end else if (en) begin
      if (sel) begin
        r_data <= load_data;
        r_vld  <= 1'b1;
      end else begin
        r_data <= shift_data;
        r_vld  <= shift_vld;
      end
    end
  end

  assign data = r_data;
  assign vld  = r_vld;

endmodule
`default_nettype wire

// File: rtl/dff_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dff_pipe                                                        |
// | Brief    : WIDTH x DEPTH register pipeline with hold/shift/load/rotate     |
// |            modes and a registered occupancy count.                         |
// |            Define DFF_PIPE_TAPS_EN to expose per-stage taps and valids.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dff_pipe
  import dff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           d,
  input  logic                       d_vld,
  input  logic [WIDTH*DEPTH-1:0]     ld_data,
  output logic [WIDTH-1:0]           q,
  output logic                       q_vld,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
`ifdef DFF_PIPE_TAPS_EN
  ,
  output logic [WIDTH*DEPTH-1:0]     taps,
  output logic [DEPTH-1:0]           tap_vld
`endif
);

  localparam int c_CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0]   w_data     [DEPTH];
  logic [WIDTH-1:0]   w_src_data [DEPTH];
  logic [DEPTH-1:0]   w_vld;
  logic [DEPTH-1:0]   w_src_vld;
  logic [DEPTH-1:0]   w_vld_nxt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [c_CNT_W-1:0] r_count;
  logic               w_stage_en;
  logic               w_load;

  assign w_stage_en = en && (mode != MODE_HOLD);
  assign w_load     = (mode == MODE_LOAD);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    // Stage 0 is fed from d, or from the last stage when rotating.
    if (i == 0) begin : g_head
      assign w_src_data[i] = (mode == MODE_ROTATE) ? w_data[DEPTH-1] : d;
      assign w_src_vld[i]  = (mode == MODE_ROTATE) ? w_vld[DEPTH-1]  : d_vld;
    end else begin : g_body
      assign w_src_data[i] = w_data[i-1];
      assign w_src_vld[i]  = w_vld[i-1];
    end

    dff_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .clr        (clr),
      .en         (w_stage_en),
      .sel        (w_load),
      .shift_data (w_src_data[i]),
      .shift_vld  (w_src_vld[i]),
      .load_data  (ld_data[i*WIDTH +: WIDTH]),
      .data       (w_data[i]),
      .vld        (w_vld[i])
    );

`ifdef DFF_PIPE_TAPS_EN
    assign taps[i*WIDTH +: WIDTH] = w_data[i];
`endif
  end

  // Next-state valids mirror the stage update so the count moves on the same edge.
  always_comb begin
    w_vld_nxt = w_vld;
    if (clr) begin
      w_vld_nxt = '0;
    end else if (w_stage_en) begin
      w_vld_nxt = w_load ? '1 : w_src_vld;
    end
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt_nxt = w_cnt_nxt + c_CNT_W'(w_vld_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_cnt_nxt;
    end
  end

  assign q     = w_data[DEPTH-1];
  assign q_vld = w_vld[DEPTH-1];
  assign count = r_count;
  assign full  = (r_count == c_CNT_W'(DEPTH));
  assign empty = (r_count == '0);

`ifdef DFF_PIPE_TAPS_EN
  assign tap_vld = w_vld;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dff_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dff_pipe                                                     |
// | Brief    : Scoreboard bench for dff_pipe (WIDTH=8, DEPTH=4, RST_VAL=0).    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_dff_pipe;

  localparam int c_W = 8;
  localparam int c_D = 4;

  typedef struct packed {
    logic [7:0]  q;
    logic        q_vld;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic [31:0] taps;
    logic [3:0]  tap_vld;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clr = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  d = 8'h00;
  logic        d_vld = 1'b0;
  logic [31:0] ld_data = 32'h0;
  logic [7:0]  q;
  logic        q_vld;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic [31:0] taps;
  logic [3:0]  tap_vld;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_data [c_D];
  logic [3:0] m_vld;
  exp_t       sb_q [$];

  always #5 clk = ~clk;

  dff_pipe #(.WIDTH(c_W), .DEPTH(c_D), .RST_VAL(8'h00)) dut (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .en      (en),
    .mode    (mode),
    .d       (d),
    .d_vld   (d_vld),
    .ld_data (ld_data),
    .q       (q),
    .q_vld   (q_vld),
    .count   (count),
    .full    (full),
    .empty   (empty)
`ifdef DFF_PIPE_TAPS_EN
    ,
    .taps    (taps),
    .tap_vld (tap_vld)
`endif
  );

`ifndef DFF_PIPE_TAPS_EN
  assign taps    = 32'h0;
  assign tap_vld = 4'h0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    int   n = 0;
    for (int i = 0; i < c_D; i++) n += int'(m_vld[i]);
    e.q       = m_data[c_D-1];
    e.q_vld   = m_vld[c_D-1];
    e.count   = 3'(n);
    e.full    = (n == c_D);
    e.empty   = (n == 0);
    e.taps    = {m_data[3], m_data[2], m_data[1], m_data[0]};
    e.tap_vld = m_vld;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < c_D; i++) m_data[i] = 8'h00;
    m_vld = 4'h0;
  endtask

  task automatic compare(input string tag, input exp_t e);
    check({tag, ".q"},     32'(q),     32'(e.q));
    check({tag, ".q_vld"}, 32'(q_vld), 32'(e.q_vld));
    check({tag, ".count"}, 32'(count), 32'(e.count));
    check({tag, ".full"},  32'(full),  32'(e.full));
    check({tag, ".empty"}, 32'(empty), 32'(e.empty));
`ifdef DFF_PIPE_TAPS_EN
    check({tag, ".taps"},    taps,           e.taps);
    check({tag, ".tap_vld"}, 32'(tap_vld),   32'(e.tap_vld));
`endif
  endtask

  // Drive one edge worth of stimulus, advance the model, then score the DUT.
  task automatic step(input string tag, input logic c, input logic e, input logic [1:0] m,
                      input logic [7:0] dd, input logic dv, input logic [31:0] ld);
    logic [7:0] last;
    logic       last_v;
    exp_t       got_e;
    @(negedge clk);
    clr = c; en = e; mode = m; d = dd; d_vld = dv; ld_data = ld;
    if (c) begin
      model_reset();
    end else if (e) begin
      case (m)
        2'b01, 2'b11: begin
          last   = m_data[c_D-1];
          last_v = m_vld[c_D-1];
          for (int i = c_D-1; i > 0; i--) begin
            m_data[i] = m_data[i-1];
            m_vld[i]  = m_vld[i-1];
          end
          m_data[0] = (m == 2'b11) ? last : dd;
          m_vld[0]  = (m == 2'b11) ? last_v : dv;
        end
        2'b10: begin
          for (int i = 0; i < c_D; i++) m_data[i] = ld[i*8 +: 8];
          m_vld = 4'hF;
        end
        default: ;
      endcase
    end
    sb_q.push_back(model_expect());
    @(posedge clk);
    #1;
    got_e = sb_q.pop_front();
    compare(tag, got_e);
  endtask

  initial begin
    model_reset();

    // Reset held with clock running and d toggling.
    en = 1'b1; mode = 2'b01; d_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d = 8'(8'hA5 ^ i);
      #1;
      compare("in_reset", model_expect());
    end
    @(negedge clk);
    en = 1'b0; mode = 2'b00; d_vld = 1'b0;
    reset = 1'b1;
    step("after_release", 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 32'h0);

    // Serial fill.
    step("shift1", 1'b0, 1'b1, 2'b01, 8'h11, 1'b1, 32'h0);
    step("shift2", 1'b0, 1'b1, 2'b01, 8'h22, 1'b1, 32'h0);
    step("shift3", 1'b0, 1'b1, 2'b01, 8'h33, 1'b1, 32'h0);
    step("shift4", 1'b0, 1'b1, 2'b01, 8'h44, 1'b1, 32'h0);
    check("fill_q_literal", 32'(q), 32'h11);

    // Parallel load then a full rotation.
    step("load", 1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 32'h44332211);
    for (int i = 0; i < 4; i++)
      step($sformatf("rot%0d", i), 1'b0, 1'b1, 2'b11, 8'hEE, 1'b0, 32'h0);
    check("rot_q_literal", 32'(q), 32'h44);

    // Drain with invalid data, freezing for 3 cycles in the middle.
    step("drain1", 1'b0, 1'b1, 2'b01, 8'h55, 1'b0, 32'h0);
    step("drain2", 1'b0, 1'b1, 2'b01, 8'h66, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++)
      step($sformatf("freeze%0d", i), 1'b0, 1'b0, 2'b01, 8'h77, 1'b1, 32'hFFFFFFFF);
    step("hold_mode", 1'b0, 1'b1, 2'b00, 8'h99, 1'b1, 32'h0);
    step("drain3", 1'b0, 1'b1, 2'b01, 8'h88, 1'b0, 32'h0);
    step("drain4", 1'b0, 1'b1, 2'b01, 8'h99, 1'b0, 32'h0);
    check("drain_empty_literal", 32'(empty), 32'h1);

    // Clear beats disabled load on the same edge.
    step("reload", 1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 32'hDEADBEEF);
    step("clr_wins", 1'b1, 1'b0, 2'b10, 8'h00, 1'b1, 32'hCAFEF00D);

    // Asynchronous reset pulse between edges.
    step("reload2", 1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 32'h0BADCAFE);
    @(negedge clk);
    clr = 1'b0; en = 1'b0; mode = 2'b00;
    reset = 1'b0;
    #1;
    model_reset();
    compare("async_rst", model_expect());
    #1;
    reset = 1'b1;
    step("post_async", 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 32'h0);

`ifdef DFF_PIPE_TAPS_EN
    // Taps after a serial fill.
    for (int i = 0; i < 4; i++)
      step($sformatf("tfill%0d", i), 1'b0, 1'b1, 2'b01, 8'(8'h11 * (i + 1)), 1'b1, 32'h0);
    check("taps_literal", taps, 32'h11223344);
    check("tap_vld_literal", 32'(tap_vld), 32'hF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
